jtbubl_objdraw: RTL and testbench

//  Parametrised object-row drawer for the jtbubl line-buffer pipeline.
//  - Takes one draw request (base code, tile count, palette, flips, row, x) from the scan logic.
//  - Fetches one 32-bit, 4bpp, 8-pixel row per tile over the SDRAM rom_cs/rom_ok handshake.
//  - Writes pixels into the object line buffer.
//  - Beyond the previous drawer: multi-tile strips, h-flip order reversal, transparency skip,

---
 rtl/jtbubl_objdraw_pkg.sv | 35 +++
 rtl/jtbubl_objdraw_shift.sv | 73 +++++++
 rtl/jtbubl_objdraw.sv | 160 ++++++++++++++++
 tb/tb_jtbubl_objdraw.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtbubl_objdraw_pkg.sv
// Shared graphics constants, FSM state encoding and pixel unpack helper for the
// object-row drawer.
//   ROM_DW / BPP / TILE_W : ROM word width, bits per pixel, pixels per tile row
//   objdraw_state_e       : drawer FSM states
//   jtbubl_unpack()       : raw 4-bit pixel k of a 32-bit tile row, with h-flip
package jtbubl_objdraw_pkg;

    localparam int unsigned ROM_DW = 32;
    localparam int unsigned BPP    = 4;
    localparam int unsigned TILE_W = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDraw  = 2'd2
    } objdraw_state_e;

    // Plane p is the byte {rom_data[16+4p +: 4], rom_data[4p +: 4]}; pixel k is bit k
    // of every plane. With hflip the pixel order is mirrored (7-k == ~k on 3 bits).
    function automatic logic [BPP-1:0] jtbubl_unpack(input logic [ROM_DW-1:0] rom_data,
                                                     input logic              hflip,
                                                     input logic [2:0]        k);
        logic [2:0]       kk;
        logic [7:0]       plane;
        logic [BPP-1:0]   pix;
        kk  = hflip ? ~k : k;
        pix = '0;
        for (int p = 0; p < int'(BPP); p++) begin
            plane  = {rom_data[16+4*p +: 4], rom_data[4*p +: 4]};
            pix[p] = plane[kk];
        end
        return pix;
    endfunction

endpackage

// File: rtl/jtbubl_objdraw_shift.sv
// Plane shift register for one tile row.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture din (pixel order already resolved using dir)
//   shift      : advance to the next pixel
//   dir        : horizontal flip of the row being loaded
//   din        : 32-bit ROM tile row
//   pixel      : raw 4-bit pixel currently at the head of the register
//   cnt        : index of the current pixel, 0..7
module jtbubl_objdraw_shift
    import jtbubl_objdraw_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic              dir,
    input  logic [ROM_DW-1:0] din,
    output logic [BPP-1:0]    pixel,
    output logic [2:0]        cnt
);

    // Four 8-bit planes; the pixel to emit sits in bit 0 of every plane.
    logic [ROM_DW-1:0] sr_q, sr_d;
    logic [ROM_DW-1:0] loaded;
    logic [BPP-1:0]    px;
    logic [2:0]        cnt_q, cnt_d;

    // Reorder into emission order once at load so the shift is always rightward.
    always_comb begin
        loaded = '0;
        px     = '0;
        for (int k = 0; k < int'(TILE_W); k++) begin
            px = jtbubl_unpack(din, dir, 3'(k));
            for (int p = 0; p < int'(BPP); p++) begin
                loaded[p*TILE_W + k] = px[p];
            end
        end
    end

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = loaded;
            cnt_d = '0;
        end else if (shift) begin
            for (int p = 0; p < int'(BPP); p++) begin
                sr_d[p*TILE_W +: TILE_W] = {1'b0, sr_q[p*TILE_W+1 +: TILE_W-1]};
            end
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        pixel = '0;
        for (int p = 0; p < int'(BPP); p++) begin
            pixel[p] = sr_q[p*TILE_W];
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/jtbubl_objdraw.sv
// Object-row drawer: takes one strip request, fetches one 32-bit 4bpp row per
// tile over the rom_cs/rom_ok handshake and writes 8 pixels per tile into the
// object line buffer.
//   clk, rst_n            : clock, synchronous active-low reset
//   flush                 : abort current strip, return to idle
//   draw_req / draw_busy  : request (level) / busy from acceptance to completion
//   tile_*                : strip description, latched on acceptance
//   rom_addr/cs/ok/data   : SDRAM tile-row fetch
//   buf_addr/data/we      : line buffer write port
module jtbubl_objdraw
    import jtbubl_objdraw_pkg::*;
#(
    parameter int unsigned    CW      = 14,
    parameter int unsigned    PW      = 4,
    parameter int unsigned    AW      = 9,
    parameter int unsigned    VW      = 3,
    parameter int unsigned    NW      = 2,
    parameter bit             INVERT  = 1'b1,
    parameter bit             TRSP_EN = 1'b1,
    parameter logic [BPP-1:0] TRSP    = 4'hf
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              draw_req,
    output logic              draw_busy,
    input  logic [CW-1:0]     tile_code,
    input  logic [NW-1:0]     tile_n,
    input  logic [PW-1:0]     tile_pal,
    input  logic              tile_hflip,
    input  logic              tile_vflip,
    input  logic [VW-1:0]     tile_row,
    input  logic [AW-1:0]     tile_x,
    output logic [CW+VW:0]    rom_addr,
    output logic              rom_cs,
    input  logic              rom_ok,
    input  logic [ROM_DW-1:0] rom_data,
    output logic [AW-1:0]     buf_addr,
    output logic [PW+3:0]     buf_data,
    output logic              buf_we
);

    objdraw_state_e state_q, state_d;
    logic [CW-1:0]  code_q, code_d;
    logic [NW-1:0]  left_q, left_d;   // tiles still to fetch after the current one
    logic [PW-1:0]  pal_q, pal_d;
    logic           hflip_q, hflip_d;
    logic           vflip_q, vflip_d;
    logic [VW-1:0]  row_q, row_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           first_q, first_d; // first FETCH cycle: rom_ok may be stale

    logic           sh_load, sh_shift;
    logic [BPP-1:0] pix_raw, colour;
    logic [2:0]     pix_cnt;
    logic           drawing;

    jtbubl_objdraw_shift u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sh_load),
        .shift (sh_shift),
        .dir   (hflip_q),
        .din   (rom_data),
        .pixel (pix_raw),
        .cnt   (pix_cnt)
    );

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        left_d   = left_q;
        pal_d    = pal_q;
        hflip_d  = hflip_q;
        vflip_d  = vflip_q;
        row_d    = row_q;
        addr_d   = addr_q;
        first_d  = first_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (draw_req && !flush) begin
                    // h-flipped strips start from the last tile and step down
                    code_d  = tile_hflip ? tile_code + CW'(tile_n) : tile_code;
                    left_d  = tile_n;
                    pal_d   = tile_pal;
                    hflip_d = tile_hflip;
                    vflip_d = tile_vflip;
                    row_d   = tile_row;
                    addr_d  = tile_x;
                    first_d = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                first_d = 1'b0;
                if (!first_q && rom_ok) begin
                    sh_load = 1'b1;
                    state_d = StDraw;
                end
            end
            StDraw: begin
                sh_shift = 1'b1;
                addr_d   = addr_q + AW'(1);
                if (pix_cnt == 3'd7) begin
                    if (left_q != '0) begin
                        left_d  = left_q - NW'(1);
                        code_d  = hflip_q ? code_q - CW'(1) : code_q + CW'(1);
                        first_d = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            code_q  <= '0;
            left_q  <= '0;
            pal_q   <= '0;
            hflip_q <= 1'b0;
            vflip_q <= 1'b0;
            row_q   <= '0;
            addr_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            left_q  <= left_d;
            pal_q   <= pal_d;
            hflip_q <= hflip_d;
            vflip_q <= vflip_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        drawing   = (state_q == StDraw);
        colour    = INVERT ? ~pix_raw : pix_raw;
        draw_busy = (state_q != StIdle);
        rom_cs    = (state_q == StFetch);
        rom_addr  = {code_q, row_q ^ {VW{vflip_q}}, 1'b0};
        buf_addr  = addr_q;
        // address still advances on transparent pixels, only the strobe is dropped
        buf_we    = drawing && !(TRSP_EN && (colour == TRSP));
        buf_data  = drawing ? {pal_q, colour} : '0;
    end

endmodule

// File: tb/tb_jtbubl_objdraw.sv
`timescale 1ns/1ps
module tb_jtbubl_objdraw;
    localparam int CW = 14;
    localparam int PW = 4;
    localparam int AW = 9;
    localparam int VW = 3;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          draw_req = 1'b0;
    logic [CW-1:0] tile_code = '0;
    logic [NW-1:0] tile_n = '0;
    logic [PW-1:0] tile_pal = '0;
    logic          tile_hflip = 1'b0;
    logic          tile_vflip = 1'b0;
    logic [VW-1:0] tile_row = '0;
    logic [AW-1:0] tile_x = '0;
    logic          rom_ok = 1'b0;
    logic [31:0]   rom_data;

    logic          draw_busy, draw_busy0;
    logic [CW+VW:0] rom_addr, rom_addr0;
    logic          rom_cs, rom_cs0;
    logic [AW-1:0] buf_addr, buf_addr0;
    logic [PW+3:0] buf_data, buf_data0;
    logic          buf_we, buf_we0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_acc = 0;
    int ok_delay = 0;
    logic stale = 1'b0;
    logic rom_zero = 1'b0;

    logic [16:0]    q1[$];  // {addr, data} expected from transparent-skip DUT
    logic [16:0]    q0[$];  // {addr, data} expected from DUT writing every pixel
    logic [CW+VW:0] qr[$];  // expected fetch addresses

    function automatic logic [31:0] rom_pat(input logic [CW+VW:0] a);
        return {a[15:0] ^ 16'h3C5A, a[17:2] ^ 16'hE1B7};
    endfunction

    assign rom_data = rom_zero ? 32'h0 : rom_pat(rom_addr);

    jtbubl_objdraw u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .draw_req(draw_req), .draw_busy(draw_busy),
        .tile_code(tile_code), .tile_n(tile_n), .tile_pal(tile_pal), .tile_hflip(tile_hflip),
        .tile_vflip(tile_vflip), .tile_row(tile_row), .tile_x(tile_x), .rom_addr(rom_addr),
        .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data), .buf_addr(buf_addr),
        .buf_data(buf_data), .buf_we(buf_we)
    );

    jtbubl_objdraw #(.TRSP_EN(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .draw_req(draw_req), .draw_busy(draw_busy0),
        .tile_code(tile_code), .tile_n(tile_n), .tile_pal(tile_pal), .tile_hflip(tile_hflip),
        .tile_vflip(tile_vflip), .tile_row(tile_row), .tile_x(tile_x), .rom_addr(rom_addr0),
        .rom_cs(rom_cs0), .rom_ok(rom_ok), .rom_data(rom_data), .buf_addr(buf_addr0),
        .buf_data(buf_data0), .buf_we(buf_we0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic cyc_loop();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    // ROM model: rom_ok rises ok_delay cycles into a fetch; with stale set it is
    // also high in the idle cycle and in the first fetch cycle.
    task automatic rom_loop();
        int cs_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rom_cs) cs_cnt++;
            else cs_cnt = 0;
            rom_ok = (stale && cs_cnt <= 1) || (cs_cnt >= ok_delay);
        end
    endtask

    task automatic mon_loop();
        logic [16:0]    e;
        logic [CW+VW:0] ea;
        logic           cs_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (buf_we) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_trsp: got write %h=%h, required none", buf_addr, buf_data);
                end else begin
                    e = q1.pop_front();
                    chk("wr_trsp", 64'({buf_addr, buf_data}), 64'(e));
                end
            end
            if (buf_we0) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_all: got write %h=%h, required none", buf_addr0, buf_data0);
                end else begin
                    e = q0.pop_front();
                    chk("wr_all", 64'({buf_addr0, buf_data0}), 64'(e));
                end
            end
            if (rom_cs && !cs_prev) begin
                if (qr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rom_addr: got fetch %h, required none", rom_addr);
                end else begin
                    ea = qr.pop_front();
                    chk("rom_addr", 64'(rom_addr), 64'(ea));
                    chk("rom_addr0", 64'(rom_addr0), 64'(ea));
                end
            end
            cs_prev = rom_cs;
        end
    endtask

    // Expected fetches and writes for a strip, truncated after 'limit' pixels.
    task automatic expect_strip(input logic [CW-1:0] c, input logic [NW-1:0] n,
                                input logic [PW-1:0] pal, input logic hf, input logic vf,
                                input logic [VW-1:0] row, input logic [AW-1:0] x,
                                input int limit);
        logic [CW-1:0]  code;
        logic [CW+VW:0] ra;
        logic [31:0]    d;
        logic [3:0]     raw, col;
        logic [AW-1:0]  a;
        int             kk;
        for (int t = 0; t <= int'(n); t++) begin
            if (t * 8 >= limit) break;
            code = hf ? c + CW'(n) - CW'(t) : c + CW'(t);
            ra   = {code, row ^ {VW{vf}}, 1'b0};
            qr.push_back(ra);
            d = rom_zero ? 32'h0 : rom_pat(ra);
            for (int k = 0; k < 8; k++) begin
                if (t * 8 + k >= limit) break;
                kk = hf ? 7 - k : k;
                for (int p = 0; p < 4; p++) begin
                    raw[p] = (kk < 4) ? d[4*p + kk] : d[16 + 4*p + kk - 4];
                end
                col = ~raw;
                a   = x + AW'(t * 8 + k);
                q0.push_back({a, pal, col});
                if (col != 4'hF) q1.push_back({a, pal, col});
            end
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [CW-1:0] c, input logic [NW-1:0] n,
                         input logic [PW-1:0] pal, input logic hf, input logic vf,
                         input logic [VW-1:0] row, input logic [AW-1:0] x);
        tile_code = c; tile_n = n; tile_pal = pal; tile_hflip = hf;
        tile_vflip = vf; tile_row = row; tile_x = x;
        draw_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (draw_busy) break;
        end
        draw_req = 1'b0;
        chk("accept", 64'(draw_busy), 64'd1);
        t_acc = cyc;
    endtask

    task automatic wait_done(input int exp_cycles);
        for (int i = 0; i < 400; i++) begin
            if (!draw_busy) break;
            @(posedge clk);
            #1;
        end
        chk("done", 64'(draw_busy), 64'd0);
        chk("busy_cycles", 64'(cyc - t_acc), 64'(exp_cycles));
        chk("queues_empty", 64'(q1.size() + q0.size() + qr.size()), 64'd0);
    endtask

    initial begin
        logic [2:0] lat;
        fork
            cyc_loop();
            rom_loop();
            mon_loop();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 64'({draw_busy, rom_cs, buf_we, buf_addr, buf_data}), 64'd0);
        chk("reset_rom_addr", 64'(rom_addr), 64'd0);
        chk("reset_outs0", 64'({draw_busy0, rom_cs0, buf_we0, buf_addr0, buf_data0}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single tile of all-zero data -> inverted colour F everywhere
        rom_zero = 1'b1;
        qr.push_back({14'h123, 3'd2, 1'b0});
        for (int k = 0; k < 8; k++) q0.push_back({9'h010 + 9'(k), 8'h5F});
        issue(14'h123, 2'd0, 4'h5, 1'b0, 1'b0, 3'd2, 9'h010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lat[i] = buf_we0;
        end
        chk("latency", 64'(lat), 64'b100);
        wait_done(10);
        rom_zero = 1'b0;

        // 2: strip with both flips, then the same strip without h-flip
        expect_strip(14'h2A0, 2'd2, 4'h9, 1'b1, 1'b1, 3'd1, 9'h040, 999);
        issue(14'h2A0, 2'd2, 4'h9, 1'b1, 1'b1, 3'd1, 9'h040);
        wait_done(30);
        expect_strip(14'h2A0, 2'd2, 4'h9, 1'b0, 1'b1, 3'd1, 9'h080, 999);
        issue(14'h2A0, 2'd2, 4'h9, 1'b0, 1'b1, 3'd1, 9'h080);
        wait_done(30);

        // 3: line buffer address wrap, with code wrap across the strip
        expect_strip(14'h3FFF, 2'd1, 4'h2, 1'b0, 1'b0, 3'd7, 9'h1FC, 999);
        issue(14'h3FFF, 2'd1, 4'h2, 1'b0, 1'b0, 3'd7, 9'h1FC);
        wait_done(20);

        // 4: stale rom_ok at acceptance, real data only 5 cycles later
        stale = 1'b1;
        ok_delay = 6;
        @(posedge clk);
        #1;
        expect_strip(14'h055, 2'd0, 4'h3, 1'b0, 1'b0, 3'd4, 9'h0A0, 999);
        issue(14'h055, 2'd0, 4'h3, 1'b0, 1'b0, 3'd4, 9'h0A0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stale_wait", 64'({rom_cs, buf_we0}), 64'b10);
        end
        wait_done(14);
        stale = 1'b0;
        ok_delay = 0;
        @(posedge clk);
        #1;

        // 5: flush while pixel 3 of the first tile is being written
        expect_strip(14'h111, 2'd1, 4'hC, 1'b0, 1'b0, 3'd5, 9'h100, 4);
        issue(14'h111, 2'd1, 4'hC, 1'b0, 1'b0, 3'd5, 9'h100);
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        draw_req = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_outs", 64'({buf_we, buf_we0, draw_busy, draw_busy0, rom_cs}), 64'd0);
        @(posedge clk);
        #1;
        chk("flush_req_ignored", 64'({draw_busy, draw_busy0}), 64'd0);
        flush = 1'b0;
        draw_req = 1'b0;
        @(posedge clk);
        #1;
        chk("flush_idle", 64'({draw_busy, rom_cs}), 64'd0);
        chk("flush_queues", 64'(q1.size() + q0.size() + qr.size()), 64'd0);

        // 6: reset for one cycle during FETCH, then a normal strip
        qr.push_back({14'h222, 3'd3, 1'b0});
        issue(14'h222, 2'd0, 4'h7, 1'b0, 1'b0, 3'd3, 9'h0C0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_outs", 64'({draw_busy, rom_cs, buf_we, buf_addr, buf_data}), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_busy0", 64'({draw_busy0, buf_we0}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_strip(14'h222, 2'd1, 4'h7, 1'b0, 1'b0, 3'd3, 9'h0C0, 999);
        issue(14'h222, 2'd1, 4'h7, 1'b0, 1'b0, 3'd3, 9'h0C0);
        wait_done(20);

        repeat (4) @(posedge clk);
        #1;
        chk("final_queues", 64'(q1.size() + q0.size() + qr.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
